// File: rtl/channel_demultiplexer.sv
// channel_demultiplexer: routes a c001-framed GLIP stream onto per-channel valid/ready lanes.
// Define CHANNEL_DEMUX_STATS_EN to add saturating err_count/drop_count outputs.
module channel_demultiplexer #(
  parameter int WIDTH = 16,
  parameter int CHANN = 8
) (
  input  logic                        clk,
  input  logic                        com_rst,
  input  logic                        fifo_in_valid,
  output logic                        fifo_in_ready,
  input  logic [WIDTH-1:0]            fifo_in_data,
  output logic [CHANN-1:0]            fifo_in_valid_channel,
  input  logic [CHANN-1:0]            fifo_in_ready_channel,
  output logic [CHANN-1:0][WIDTH-1:0] fifo_in_data_channel,
  output logic                        proto_err
`ifdef CHANNEL_DEMUX_STATS_EN
  ,
  output logic [15:0]                 err_count,
  output logic [15:0]                 drop_count
`endif
);
  localparam int CW = CHANN > 1 ? $clog2(CHANN) : 1;
  typedef enum logic [1:0] {DROP, DATA, ESC, ESC_DROP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cur_chan, chan_nxt, hold_chan;
  logic [WIDTH-1:0] hold_data;
  logic hold_valid, accept, is_esc, is_hdr, hdr_ok, load, err;
  always_comb begin
    is_esc = fifo_in_data == 16'hc001;
    is_hdr = fifo_in_data[15:8] == 8'hab;
    hdr_ok = {1'b0, fifo_in_data[7:0]} < 9'(CHANN);
    fifo_in_ready = !hold_valid || fifo_in_ready_channel[hold_chan];
    accept = fifo_in_valid && fifo_in_ready;
    state_nxt = state;
    chan_nxt = cur_chan;
    load = 1'b0;
    err = 1'b0;
    if (accept)
      case (state)
        DROP: state_nxt = is_esc ? ESC_DROP : DROP;
        DATA: begin
          state_nxt = is_esc ? ESC : DATA;
          load = !is_esc;
        end
        default:
          if (is_esc) begin
            state_nxt = state == ESC ? DATA : DROP;
            load = state == ESC;
          end else if (is_hdr) begin
            chan_nxt = fifo_in_data[CW-1:0];
            state_nxt = hdr_ok ? DATA : DROP;
          end else begin
            err = 1'b1;
            state_nxt = DROP;
          end
      endcase
  end
  always_comb begin
    fifo_in_valid_channel = '0;
    fifo_in_data_channel = '0;
    for (int i = 0; i < CHANN; i++) begin
      fifo_in_valid_channel[i] = hold_valid && hold_chan == CW'(i);
      fifo_in_data_channel[i] = hold_data;
    end
  end
  always_ff @(posedge clk or posedge com_rst)
    if (com_rst) begin
      state <= DROP;
      cur_chan <= '0;
      hold_valid <= 1'b0;
      hold_data <= '0;
      hold_chan <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cur_chan <= chan_nxt;
      hold_valid <= load || (hold_valid && !fifo_in_ready_channel[hold_chan]);
      if (load) begin
        hold_data <= fifo_in_data;
        hold_chan <= CHANN == 1 ? '0 : cur_chan;
      end
      proto_err <= err;
    end
`ifdef CHANNEL_DEMUX_STATS_EN
  logic drop;
  assign drop = accept && ((state == DROP && !is_esc) || (state == ESC_DROP && is_esc));
  always_ff @(posedge clk or posedge com_rst)
    if (com_rst) begin
      err_count <= '0;
      drop_count <= '0;
    end else begin
      if (err && err_count != 16'hffff) err_count <= err_count + 16'd1;
      if (drop && drop_count != 16'hffff) drop_count <= drop_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_channel_demultiplexer.sv
// tb_channel_demultiplexer: scoreboard bench with a word-level framing model and random traffic.
module tb_channel_demultiplexer;
  localparam int W = 16;
  localparam int N = 8;
  logic clk = 1'b0;
  logic com_rst = 1'b1;
  logic fifo_in_valid = 1'b0;
  logic fifo_in_ready;
  logic [W-1:0] fifo_in_data = '0;
  logic [N-1:0] fifo_in_valid_channel;
  logic [N-1:0] fifo_in_ready_channel = '1;
  logic [N-1:0][W-1:0] fifo_in_data_channel;
  logic proto_err;
`ifdef CHANNEL_DEMUX_STATS_EN
  logic [15:0] err_count, drop_count;
`endif
  int total = 0, bad = 0;
  logic [23:0] q[$];
  bit esc_p = 0, in_frame = 0, rnd_ready = 0;
  logic [7:0] chan = '0;
  int exp_err = 0, exp_drop = 0, seen_err = 0;
  time t0;

  channel_demultiplexer #(.WIDTH(W), .CHANN(N)) dut (
    .clk(clk), .com_rst(com_rst),
    .fifo_in_valid(fifo_in_valid), .fifo_in_ready(fifo_in_ready), .fifo_in_data(fifo_in_data),
    .fifo_in_valid_channel(fifo_in_valid_channel), .fifo_in_ready_channel(fifo_in_ready_channel),
    .fifo_in_data_channel(fifo_in_data_channel), .proto_err(proto_err)
`ifdef CHANNEL_DEMUX_STATS_EN
    , .err_count(err_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Stream parser: c001 escapes the next word, which is a literal c001, a header, or an error.
  function automatic void model(input logic [15:0] w);
    if (!esc_p) begin
      if (w == 16'hc001) esc_p = 1;
      else if (in_frame) q.push_back({chan, w});
      else exp_drop++;
    end else begin
      esc_p = 0;
      if (w == 16'hc001) begin
        if (in_frame) q.push_back({chan, w});
        else exp_drop++;
      end else if (w[15:8] == 8'hab) begin
        chan = w[7:0];
        in_frame = int'(w[7:0]) < N;
      end else begin
        exp_err++;
        in_frame = 0;
      end
    end
  endfunction

  task automatic model_reset();
    esc_p = 0;
    in_frame = 0;
    chan = '0;
    exp_err = 0;
    exp_drop = 0;
    seen_err = 0;
    q.delete();
  endtask

  task automatic send(input logic [15:0] w);
    bit acc;
    fifo_in_valid = 1'b1;
    fifo_in_data = w;
    for (int k = 0; k < 64; k++) begin
      if (rnd_ready) fifo_in_ready_channel = N'($urandom);
      @(negedge clk);
      acc = fifo_in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        model(w);
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    fifo_in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    com_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(fifo_in_valid_channel), 32'd0);
    chk("rst_ready", 32'(fifo_in_ready), 32'd1);
    chk("rst_err", 32'(proto_err), 32'd0);
    com_rst = 1'b0;
    model_reset();
  endtask

  task automatic stats_chk(input string name);
`ifdef CHANNEL_DEMUX_STATS_EN
    chk({name, "_errcnt"}, 32'(err_count), 32'(exp_err));
    chk({name, "_dropcnt"}, 32'(drop_count), 32'(exp_drop));
`endif
    chk({name, "_errpulses"}, 32'(seen_err), 32'(exp_err));
    chk({name, "_pending"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    fork
      forever begin
        int nv, vi;
        logic [23:0] e;
        @(negedge clk);
        if (!com_rst) begin
          nv = 0;
          vi = 0;
          for (int i = 0; i < N; i++)
            if (fifo_in_valid_channel[i]) begin
              nv++;
              vi = i;
            end
          chk("onehot", 32'(nv <= 1), 32'd1);
          chk("in_ready", 32'(fifo_in_ready), 32'(nv == 0 || fifo_in_ready_channel[vi]));
          if (nv == 1 && fifo_in_ready_channel[vi]) begin
            total++;
            if (q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_out ch=%0d data=%h expected none", vi, fifo_in_data_channel[vi]);
            end else begin
              e = q.pop_front();
              if ({8'(vi), fifo_in_data_channel[vi]} !== e) begin
                bad++;
                $display("FAIL out ch/data actual=%0d/%h expected=%0d/%h", vi, fifo_in_data_channel[vi], e[23:16], e[15:0]);
              end
            end
          end
          if (proto_err) seen_err++;
        end
      end
    join_none
    do_reset();
    send(16'hc001); send(16'hab03); send(16'h1111);
    chk("latency_valid", 32'(fifo_in_valid_channel), 32'h08);
    chk("latency_data", 32'(fifo_in_data_channel[3]), 32'h1111);
    t0 = $time;
    send(16'h2222);
    chk("throughput", 32'($time - t0), 32'd10);
    idle(3);
    stats_chk("basic");
    send(16'hc001); send(16'hab05); send(16'hc001); send(16'hc001); send(16'h00aa);
    idle(3);
    stats_chk("escape");
    send(16'hc001); send(16'hab02);
    fifo_in_ready_channel[2] = 1'b0;
    send(16'h0001);
    fifo_in_valid = 1'b1;
    fifo_in_data = 16'h0002;
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready", 32'(fifo_in_ready), 32'd0);
      chk("bp_hold", 32'(fifo_in_data_channel[2]), 32'h0001);
      @(posedge clk);
      #1;
    end
    fifo_in_ready_channel = '1;
    send(16'h0002); send(16'h0003);
    idle(3);
    stats_chk("backpressure");
    foreach (q[i]) chk("never", 32'd0, 32'd1);
    send(16'hc001); send(16'hab01); send(16'haaaa);
    send(16'hc001); send(16'hab09); send(16'hbbbb);
    send(16'hc001); send(16'hab00); send(16'hcccc);
    idle(3);
    chk("switch_drops", 32'(exp_drop), 32'd1);
    stats_chk("switch");
    do_reset();
    send(16'h1234); send(16'hc001); send(16'h5555); send(16'h6666);
    idle(3);
    chk("ferr_pulses", 32'(seen_err), 32'd1);
    stats_chk("framing");
    send(16'hc001); send(16'hab04);
    fifo_in_ready_channel[4] = 1'b0;
    send(16'h4444);
    chk("pre_rst_valid", 32'(fifo_in_valid_channel), 32'h10);
    #2 com_rst = 1'b1;
    #1 chk("async_rst_valid", 32'(fifo_in_valid_channel), 32'd0);
    model_reset();
    @(posedge clk);
    #1 com_rst = 1'b0;
    fifo_in_ready_channel = '1;
    send(16'h7777);
    idle(4);
    chk("post_rst_valid", 32'(fifo_in_valid_channel), 32'd0);
    stats_chk("midreset");
    rnd_ready = 1;
    for (int n = 0; n < 500; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) send(16'hc001);
      else if (r < 5) send({8'hab, 8'($urandom_range(0, 11))});
      else send(16'($urandom));
    end
    rnd_ready = 0;
    fifo_in_ready_channel = '1;
    idle(10);
    stats_chk("random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/channel_demultiplexer.md
Name: channel_demultiplexer

Overview:
- Host-to-target counterpart of the channel multiplexing path.
- Consumes one GLIP FIFO input stream framed with control word 16'hc001, channel header {8'hab, ch}, and doubled-c001 escaping.
- Routes each payload word to the valid/ready interface of channel ch; all logic in the GLIP clock domain.
- Per-channel clock crossing, where needed, is done by FIFOs outside this block.

Parameters:
- WIDTH, 16: word width. Only 16 is legal; the framing words are 16 bits.
- CHANN, 8: number of output channels, 1..256.

Ports:
- clk  input  1  GLIP clock; all state on its rising edge.
- com_rst  input  1  asynchronous, active-high reset.
- fifo_in_valid  input  1  input stream word valid.
- fifo_in_ready  output  1  input stream word accepted when valid && ready.
- fifo_in_data  input  WIDTH  input stream word.
- fifo_in_valid_channel  output  CHANN  per-channel word valid.
- fifo_in_ready_channel  input  CHANN  per-channel ready.
- fifo_in_data_channel  output  CHANN x WIDTH  per-channel data; all lanes carry the same held word.
- proto_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (com_rst high, asynchronous):
  - state=DROP, cur_chan=0, hold_valid=0, hold_data=0, hold_chan=0.
  - All fifo_in_valid_channel=0, proto_err=0.
  - fifo_in_ready=1 (combinational from hold_valid=0).
  - Reset mid-operation discards the held word and the current selection.
- Output register:
  - One holding stage: hold_valid, hold_data, hold_chan.
  - fifo_in_valid_channel[i] = hold_valid && (hold_chan==i).
  - hold_valid clears when fifo_in_ready_channel[hold_chan]=1, unless it is reloaded in the same cycle.
- Input acceptance:
  - fifo_in_ready = !hold_valid || fifo_in_ready_channel[hold_chan].
  - The same rule applies to framing words; no word is consumed while fifo_in_ready=0.
  - Latency: an accepted payload word is visible on its channel in the next cycle.
  - Full throughput of 1 word/cycle while the sink is ready.
- FSM, evaluated only on accepted words:
  - DROP (no valid channel): word==c001 -> ESC_DROP; any other word is discarded.
  - DATA (channel cur_chan selected): word==c001 -> ESC; any other word loads hold_data/hold_chan=cur_chan and sets hold_valid=1.
  - ESC and ESC_DROP (next word after c001):
    - word==c001: escaped literal. In ESC it is loaded as payload and the FSM returns to DATA; in ESC_DROP it is discarded and the FSM returns to DROP.
    - word[15:8]==8'hab: header. Set cur_chan=word[7:0]. Go to DATA if word[7:0] < CHANN, else DROP.
    - Any other word: proto_err pulses for 1 cycle, the word is discarded, the FSM goes to DROP.
- Boundary conditions:
  - A header for the same channel is legal and changes nothing visible.
  - A header while hold_valid=1 does not alter hold_chan.
  - Back-to-back c001, c001, c001, c001 yields two literal c001 payload words.
  - A stream ending after a lone c001 stays in ESC indefinitely.
  - A ready on a channel that is not selected has no effect.
  - CHANN=1: hold_chan is constant 0.

Optional Feature:
- Macro CHANNEL_DEMUX_STATS_EN.
- With the macro, two extra outputs are present:
  - err_count[15:0]: counts proto_err pulses.
  - drop_count[15:0]: counts payload words discarded in DROP, including escaped literals in ESC_DROP.
  - Both counters saturate at 16'hffff, reset to 0 on com_rst, and are registered (update one cycle after the event).
- Without the macro, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Basic routing: after reset, feed c001, ab03, 1111, 2222 with all sinks ready -> channel 3 receives 1111 then 2222 on consecutive cycles; no other valid; proto_err stays 0.
- Escaping: on channel 5 feed c001, c001, 00aa -> channel 5 receives c001 then 00aa.
- Backpressure: on channel 2 feed 0001, 0002, 0003 with fifo_in_ready_channel[2]=0 for 4 cycles -> fifo_in_ready=0 after the first accept; hold_data stays 0001; after release, words arrive in order with none lost or duplicated.
- Switch and invalid channel: with CHANN=8, feed c001, ab01, aaaa, c001, ab09, bbbb, c001, ab00, cccc -> channel 1 receives aaaa, bbbb is dropped, channel 0 receives cccc (drop_count=1 with CHANNEL_DEMUX_STATS_EN).
- Framing error and early data: feed 1234 before any header -> dropped. Then feed c001, 5555 -> proto_err pulses once, FSM in DROP. Then feed 6666 -> dropped (err_count=1 with the macro).
- Reset mid-operation: assert com_rst asynchronously while hold_valid=1 on channel 4 -> all valid outputs drop immediately. After release, feed 7777 -> it is dropped until a new header is received.
